// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, encodings and operator decode for the calculator frame sequencer
package calc_pkg;

  localparam logic [7:0] OP_ADD_BYTE    = 8'h2B;
  localparam logic [7:0] OP_SUB_BYTE    = 8'h2D;
  localparam logic [7:0] OP_MUL_BYTE    = 8'h78;
  localparam logic [7:0] OP_DIV_BYTE    = 8'h2F;
  localparam logic [7:0] ERR_REPLY_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_BAD_OP  = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ALU     = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_OP, S_GET_B, S_EXEC, S_WAIT_ALU, S_SEND, S_WAIT_TX
  } state_t;

  // {valid, alu_op}; invalid bytes decode to 3'b000
  function automatic logic [2:0] decode_op(input logic [7:0] b);
    case (b)
      OP_ADD_BYTE: return {1'b1, ALU_ADD};
      OP_SUB_BYTE: return {1'b1, ALU_SUB};
      OP_MUL_BYTE: return {1'b1, ALU_MUL};
      OP_DIV_BYTE: return {1'b1, ALU_DIV};
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/calc_frame_ctrl_if.sv
// rtl/calc_frame_ctrl_if.sv - UART RX/TX, ALU handshake and status bundle for the frame sequencer
interface calc_frame_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       alu_start;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       alu_err;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       error;
  logic [1:0] err_code;

  modport master (
    input  rx_valid, rx_data, alu_done, alu_result, alu_err, tx_busy,
    output alu_start, alu_a, alu_b, alu_op, tx_start, tx_data, error, err_code
  );

  modport slave (
    output rx_valid, rx_data, alu_done, alu_result, alu_err, tx_busy,
    input  alu_start, alu_a, alu_b, alu_op, tx_start, tx_data, error, err_code
  );
endinterface

// File: rtl/calc_gap_timer.sv
// rtl/calc_gap_timer.sv - inter-byte gap down-counter; expire pulses once LOAD+1 enabled cycles pass without clr
module calc_gap_timer #(
  parameter int unsigned   W    = 1,
  parameter logic [W-1:0]  LOAD = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // clr has priority so a byte arriving on the expiry cycle is never treated as a timeout
  assign expire = en && !clr && (cnt == '0);

endmodule

// File: rtl/calc_frame_ctrl.sv
// rtl/calc_frame_ctrl.sv - 3-byte frame sequencer between UART and ALU; CALC_ERR_REPLY_EN sends 8'hEE on errors
module calc_frame_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned TIMEOUT_BYTES = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  calc_frame_ctrl_if.master bus
);

  localparam longint unsigned TIMEOUT_CYCLES =
    64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FREQ) / 64'(BAUD);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

`ifdef CALC_ERR_REPLY_EN
  localparam state_t ERR_NEXT = S_SEND;
`else
  localparam state_t ERR_NEXT = S_IDLE;
`endif

  state_t    state, state_nx;
  logic [2:0] dec;
  logic      op_valid;
  alu_op_t   op_dec;
  logic      timer_en, timer_clr, expire;
  logic      seen_busy;
  logic      tx_start_c;
  logic      take_a, take_op, take_b, take_res, err_set;
  err_code_t err_nx;

  assign dec      = decode_op(bus.rx_data);
  assign op_valid = dec[2];
  assign op_dec   = alu_op_t'(dec[1:0]);

  calc_gap_timer #(.W(TW), .LOAD(TLOAD)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (bus.rx_valid && e) state_nx = S_GET_OP;
      S_GET_OP: begin
        if (!e)                state_nx = S_IDLE;
        else if (bus.rx_valid) state_nx = op_valid ? S_GET_B : ERR_NEXT;
        else if (expire)       state_nx = ERR_NEXT;
      end
      S_GET_B: begin
        if (!e)                state_nx = S_IDLE;
        else if (bus.rx_valid) state_nx = S_EXEC;
        else if (expire)       state_nx = ERR_NEXT;
      end
      S_EXEC:     state_nx = S_WAIT_ALU;
      S_WAIT_ALU: if (bus.alu_done) state_nx = bus.alu_err ? ERR_NEXT : S_SEND;
      S_SEND:     if (!bus.tx_busy) state_nx = S_WAIT_TX;
      S_WAIT_TX:  if (seen_busy && !bus.tx_busy) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start_c = (state == S_SEND) && !bus.tx_busy;
    timer_en   = (state == S_GET_OP) || (state == S_GET_B);
    timer_clr  = bus.rx_valid || !timer_en;
    take_a     = (state == S_IDLE) && bus.rx_valid && e;
    take_op    = (state == S_GET_OP) && e && bus.rx_valid && op_valid;
    take_b     = (state == S_GET_B) && e && bus.rx_valid;
    take_res   = (state == S_WAIT_ALU) && bus.alu_done && !bus.alu_err;
    err_set    = 1'b0;
    err_nx     = ERR_NONE;
    if ((state == S_GET_OP) && e && bus.rx_valid && !op_valid) begin
      err_set = 1'b1;
      err_nx  = ERR_BAD_OP;
    end else if (timer_en && e && !bus.rx_valid && expire) begin
      err_set = 1'b1;
      err_nx  = ERR_TIMEOUT;
    end else if ((state == S_WAIT_ALU) && bus.alu_done && bus.alu_err) begin
      err_set = 1'b1;
      err_nx  = ERR_ALU;
    end
  end

  assign bus.tx_start = tx_start_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_start <= 1'b0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= '0;
      bus.tx_data   <= '0;
      bus.error     <= 1'b0;
      bus.err_code  <= '0;
      seen_busy     <= 1'b0;
    end else begin
      // registered so the launch lands two cycles after the B byte
      bus.alu_start <= (state == S_EXEC);
      if (take_a) begin
        bus.alu_a    <= bus.rx_data;
        bus.error    <= 1'b0;
        bus.err_code <= ERR_NONE;
      end
      if (take_op)  bus.alu_op  <= op_dec;
      if (take_b)   bus.alu_b   <= bus.rx_data;
      if (take_res) bus.tx_data <= bus.alu_result;
      if (err_set) begin
        bus.error    <= 1'b1;
        bus.err_code <= err_nx;
`ifdef CALC_ERR_REPLY_EN
        bus.tx_data  <= ERR_REPLY_BYTE;
`endif
      end
      if (state != S_WAIT_TX) seen_busy <= 1'b0;
      else if (bus.tx_busy)   seen_busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_frame_ctrl.sv
// tb/tb_calc_frame_ctrl.sv - directed self-checking bench for calc_frame_ctrl with ALU and UART TX models
module tb_calc_frame_ctrl;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  calc_frame_ctrl_if bus();

  calc_frame_ctrl #(.CLK_FREQ(96000), .BAUD(9600), .TIMEOUT_BYTES(20)) dut (
    .clk (clk),
    .rst (rst),
    .e   (e),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] txq[$];
  logic [7:0] last_a, last_b, ra, rb;
  logic [1:0] last_op, rop;
  int n_alu = 0;
  int t_b = 0, t_done = 0, lat_alu = -1, lat_tx = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.tx_start) begin
      txq.push_back(bus.tx_data);
      lat_tx = cyc - t_done;
    end
    if (bus.alu_start) begin
      n_alu++;
      last_a  = bus.alu_a;
      last_b  = bus.alu_b;
      last_op = bus.alu_op;
      lat_alu = cyc - t_b;
    end
  end

  initial begin
    bus.alu_done = 1'b0; bus.alu_result = '0; bus.alu_err = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.alu_start) begin
        ra = bus.alu_a; rb = bus.alu_b; rop = bus.alu_op;
        repeat (2) @(negedge clk);
        case (rop)
          2'b00: bus.alu_result = ra + rb;
          2'b01: bus.alu_result = ra - rb;
          2'b10: bus.alu_result = 8'(ra * rb);
          default: bus.alu_result = (rb == 0) ? 8'h00 : ra / rb;
        endcase
        bus.alu_err  = (rop == 2'b11) && (rb == 0);
        bus.alu_done = 1'b1;
        t_done = cyc;
        @(negedge clk);
        bus.alu_done = 1'b0;
        bus.alu_err  = 1'b0;
      end
    end
  end

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (5) @(negedge clk);
        bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t_b = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] o, input logic [7:0] b);
    send_byte(a);
    send_byte(o);
    send_byte(b);
    repeat (25) @(negedge clk);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [8:0] got;
    got = (txq.size() > 0) ? {1'b0, txq.pop_front()} : 9'h100;
    check(tag, 32'(got), 32'(exp));
  endtask

  int n0;

  initial begin
    rst = 1'b1; e = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_alu_start", 32'(bus.alu_start), 0);
    check("rst_alu_a", 32'(bus.alu_a), 0);
    check("rst_alu_b", 32'(bus.alu_b), 0);
    check("rst_alu_op", 32'(bus.alu_op), 0);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_error", 32'(bus.error), 0);
    check("rst_err_code", 32'(bus.err_code), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(8'd5, OP_ADD_BYTE, 8'd10);
    check("add_a", 32'(last_a), 5);
    check("add_b", 32'(last_b), 10);
    check("add_op", 32'(last_op), 0);
    check("alu_start_latency", 32'(lat_alu), 2);
    check("tx_start_latency", 32'(lat_tx), 1);
    expect_tx("add_tx", 8'd15);
    check("add_error", 32'(bus.error), 0);

    send_frame(8'd30, OP_SUB_BYTE, 8'd20);
    check("sub_op", 32'(last_op), 1);
    send_frame(8'd15, OP_MUL_BYTE, 8'd10);
    check("mul_op", 32'(last_op), 2);
    send_frame(8'd50, OP_DIV_BYTE, 8'd5);
    check("div_op", 32'(last_op), 3);
    expect_tx("seq_tx0", 8'd10);
    expect_tx("seq_tx1", 8'd150);
    expect_tx("seq_tx2", 8'd10);

    send_frame(8'd15, OP_DIV_BYTE, 8'd0);
    check("divz_error", 32'(bus.error), 1);
    check("divz_code", 32'(bus.err_code), 3);
`ifdef CALC_ERR_REPLY_EN
    expect_tx("divz_reply", ERR_REPLY_BYTE);
`else
    check("divz_no_tx", 32'(txq.size()), 0);
`endif

    n0 = n_alu;
    send_byte(8'd5);
    send_byte(8'h3F);
    repeat (20) @(negedge clk);
    check("badop_error", 32'(bus.error), 1);
    check("badop_code", 32'(bus.err_code), 1);
    check("badop_no_alu", 32'(n_alu), 32'(n0));
`ifdef CALC_ERR_REPLY_EN
    expect_tx("badop_reply", ERR_REPLY_BYTE);
`endif
    send_frame(8'd7, OP_ADD_BYTE, 8'd1);
    check("recover_error", 32'(bus.error), 0);
    check("recover_code", 32'(bus.err_code), 0);
    expect_tx("recover_tx", 8'd8);

    send_byte(8'd5);
    repeat (1900) @(negedge clk);
    check("gap_not_yet", 32'(bus.error), 0);
    repeat (200) @(negedge clk);
    check("gap_error", 32'(bus.error), 1);
    check("gap_code", 32'(bus.err_code), 2);
`ifdef CALC_ERR_REPLY_EN
    expect_tx("gap_reply", ERR_REPLY_BYTE);
`endif
    send_frame(8'd1, OP_ADD_BYTE, 8'd1);
    expect_tx("gap_idle_tx", 8'd2);

    send_byte(8'd9);
    @(negedge clk); e = 1'b0;
    repeat (2) @(negedge clk); e = 1'b1;
    send_frame(8'd3, OP_ADD_BYTE, 8'd4);
    check("abort_error", 32'(bus.error), 0);
    expect_tx("abort_tx", 8'd7);

    n0 = n_alu;
    send_byte(8'd40);
    send_byte(OP_SUB_BYTE);
    send_byte(8'd1);
    send_byte(OP_ADD_BYTE);
    repeat (25) @(negedge clk);
    check("overrun_alu_count", 32'(n_alu), 32'(n0 + 1));
    expect_tx("overrun_tx", 8'd39);

    send_byte(8'd6);
    send_byte(OP_ADD_BYTE);
    send_byte(8'd1);
    e = 1'b0;
    repeat (25) @(negedge clk);
    expect_tx("elow_exec_tx", 8'd7);
    n0 = n_alu;
    send_byte(8'd1);
    repeat (5) @(negedge clk);
    check("elow_idle_hold", 32'(n_alu), 32'(n0));
    e = 1'b1;

    send_byte(8'd5);
    send_byte(OP_ADD_BYTE);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_alu_a", 32'(bus.alu_a), 0);
    check("midrst_tx_data", 32'(bus.tx_data), 0);
    check("midrst_error", 32'(bus.error), 0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'd2, OP_ADD_BYTE, 8'd3);
    expect_tx("midrst_tx", 8'd5);
    check("tx_queue_empty", 32'(txq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
